full_subtractor: RTL and testbench

FULL_SUBTRACTOR -- requirements
Module: full_subtractor

---
 rtl/full_subtractor.sv | 66 ++++++
 tb/tb_full_subtractor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
//
// Purpose:
//   Parameterised ripple-borrow subtractor with a registered result.
//   The block computes d = (a - b - borrow_in) mod 2^WIDTH and a borrow out
//   of the top bit. Both outputs are registered together, so the latency is
//   one clock. A new operand set is accepted on every cycle.
//
// Parameters:
//   WIDTH      - operand width in bits (1..64), default 1
//
// Ports:
//   clk        - in,  1      : clock, rising edge
//   rst        - in,  1      : synchronous active-high reset, clears d and borrow_out
//   a          - in,  WIDTH  : minuend, unsigned
//   b          - in,  WIDTH  : subtrahend, unsigned
//   borrow_in  - in,  1      : borrow into bit 0
//   d          - out, WIDTH  : registered difference
//   borrow_out - out, 1      : registered borrow out of bit WIDTH-1
// ---------------------------------------------------------------------------
module full_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] d,
  output logic             borrow_out
);

  // bin_chain[i] is the borrow into slice i; bin_chain[WIDTH] leaves the top.
  logic [WIDTH:0]   bin_chain;
  logic [WIDTH-1:0] d_next;
  logic [WIDTH-1:0] d_reg;
  logic             borrow_out_reg;

  assign bin_chain[0] = borrow_in;

  // One full-subtractor cell per bit. A slice borrows when it must take 1
  // from 0 (a=0, b=1), or when its bits are equal and it inherits a borrow.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
      assign d_next[gi]        = a[gi] ^ b[gi] ^ bin_chain[gi];
      assign bin_chain[gi + 1] = (~a[gi] & b[gi])
                               | (~(a[gi] ^ b[gi]) & bin_chain[gi]);
    end
  endgenerate

  // Reset wins over the freshly computed result in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_reg          <= '0;
      borrow_out_reg <= 1'b0;
    end else begin
      d_reg          <= d_next;
      borrow_out_reg <= bin_chain[WIDTH];
    end
  end

  assign d          = d_reg;
  assign borrow_out = borrow_out_reg;

endmodule

// File: tb/tb_full_subtractor.sv
// ---------------------------------------------------------------------------
// tb_full_subtractor
//
// Purpose:
//   Self-checking bench for full_subtractor. Three instances (WIDTH = 1, 8
//   and 16) share one clock. Expected values come from fixed truth tables
//   and from an arithmetic reference model (plain unsigned subtraction and
//   comparison on 64-bit integers).
// ---------------------------------------------------------------------------
module tb_full_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH = 1 instance
  logic       rst1;
  logic [0:0] a1, b1, d1;
  logic       bi1, bo1;
  // WIDTH = 8 instance
  logic       rst8;
  logic [7:0] a8, b8, d8;
  logic       bi8, bo8;
  // WIDTH = 16 instance
  logic        rst16;
  logic [15:0] a16, b16, d16;
  logic        bi16, bo16;

  full_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .borrow_in(bi1),
    .d(d1), .borrow_out(bo1)
  );
  full_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .a(a8), .b(b8), .borrow_in(bi8),
    .d(d8), .borrow_out(bo8)
  );
  full_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .a(a16), .b(b16), .borrow_in(bi16),
    .d(d16), .borrow_out(bo16)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint unsigned got,
                       input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: unbounded-integer semantics of a - b - bin for w <= 32.
  function automatic void ref_sub(input int w, input longint unsigned ra,
                                  input longint unsigned rb, input bit rbin,
                                  output longint unsigned rd, output bit rbo);
    longint unsigned mask;
    mask = (64'd1 << w) - 64'd1;
    rd   = (ra - rb - 64'(rbin)) & mask;
    rbo  = (ra < rb + 64'(rbin));
  endfunction

  // Advance past the next rising edge and leave time for outputs to settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]      w1_tab [8];
    logic [7:0]      w8_a [5];
    logic [7:0]      w8_b [5];
    logic            w8_bi [5];
    logic [7:0]      w8_d [5];
    logic            w8_bo [5];
    longint unsigned ed;
    bit              ebo;
    logic [7:0]      hold_d;
    logic            hold_bo;
    int              rst_pulses;

    // {d, borrow_out} for {a, b, borrow_in} = 0..7
    w1_tab = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    w8_a  = '{8'h00, 8'h80, 8'h00, 8'hFF, 8'hFF};
    w8_b  = '{8'h01, 8'h7F, 8'h00, 8'hFF, 8'h00};
    w8_bi = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
    w8_d  = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    w8_bo = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0};

    // Reset everything with non-zero operands present.
    rst1 = 1'b1; a1 = 1'b0; b1 = 1'b1; bi1 = 1'b1;
    rst8 = 1'b1; a8 = 8'h00; b8 = 8'h55; bi8 = 1'b1;
    rst16 = 1'b1; a16 = 16'h0000; b16 = 16'h1234; bi16 = 1'b1;
    tick();
    check("rst_d1", 64'(d1), 0);
    check("rst_bo1", 64'(bo1), 0);
    check("rst_d8", 64'(d8), 0);
    check("rst_bo8", 64'(bo8), 0);
    check("rst_d16", 64'(d16), 0);
    check("rst_bo16", 64'(bo16), 0);

    // Release with a=0, b=1, bin=1: first unreset edge registers 0-1-1.
    rst1 = 1'b0;
    tick();
    check("rel_d1", 64'(d1), 0);
    check("rel_bo1", 64'(bo1), 1);

    // WIDTH=1 exhaustive truth table, back to back.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; bi1 = v[0];
      tick();
      check($sformatf("w1_d_%0d", i), 64'(d1), 64'(w1_tab[i][1]));
      check($sformatf("w1_bo_%0d", i), 64'(bo1), 64'(w1_tab[i][0]));
    end

    // WIDTH=8 directed vectors including wrap-around and boundaries.
    rst8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a8 = w8_a[i]; b8 = w8_b[i]; bi8 = w8_bi[i];
      tick();
      check($sformatf("w8_d_%0d", i), 64'(d8), 64'(w8_d[i]));
      check($sformatf("w8_bo_%0d", i), 64'(bo8), 64'(w8_bo[i]));
    end

    // WIDTH=8 glitching inputs: outputs must hold between edges and the
    // result must reflect only the values present at the edge.
    for (int r = 0; r < 4; r++) begin
      logic [7:0] fa, fb;
      logic       fbi;
      hold_d  = d8;
      hold_bo = bo8;
      fa  = 8'($urandom);
      fb  = 8'($urandom);
      fbi = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      #1;
      check($sformatf("glitch_hold_d_%0d", r), 64'(d8), 64'(hold_d));
      a8 = ~a8; bi8 = ~bi8;
      @(negedge clk);
      #1;
      check($sformatf("glitch_hold_bo_%0d", r), 64'(bo8), 64'(hold_bo));
      b8 = ~b8;
      #1;
      a8 = fa; b8 = fb; bi8 = fbi;
      ref_sub(8, 64'(fa), 64'(fb), fbi, ed, ebo);
      tick();
      check($sformatf("glitch_d_%0d", r), 64'(d8), ed);
      check($sformatf("glitch_bo_%0d", r), 64'(bo8), 64'(ebo));
    end

    // WIDTH=16 random back-to-back traffic with random reset pulses.
    rst_pulses = 0;
    for (int i = 0; i < 10000; i++) begin
      rst16 = ($urandom_range(0, 19) == 0);
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      bi16  = 1'($urandom);
      if (rst16) begin
        ed  = 0;
        ebo = 1'b0;
        rst_pulses++;
      end else begin
        ref_sub(16, 64'(a16), 64'(b16), bi16, ed, ebo);
      end
      tick();
      check($sformatf("w16_d_%0d", i), 64'(d16), ed);
      check($sformatf("w16_bo_%0d", i), 64'(bo16), 64'(ebo));
    end
    $display("random phase: 10000 vectors, %0d reset pulses", rst_pulses);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
